dlbf_data_maxis_rd: RTL

//  Per-channel BRAM port-B reader and AXI4-Stream master in the m_axis_clk domain.

---
 rtl/dlbf_data_pkg.sv | 21 ++
 rtl/dlbf_data_skid_fifo.sv | 60 ++++++
 rtl/dlbf_data_maxis_rd.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dlbf_data_pkg.sv
// Shared types for the data-path stream reader: FSM encoding, default widths
// and the skid FIFO entry layout.
package dlbf_data_pkg;

  localparam int DATA_W_DFLT = 128;
  localparam int ADDR_W_DFLT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                   tlast;
    logic [ADDR_W_DFLT-1:0] addr;
    logic [DATA_W_DFLT-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/dlbf_data_skid_fifo.sv
// Small first-word-fall-through FIFO: the head entry is visible on dout while
// not empty. Async active-low reset plus a synchronous clear.
module dlbf_data_skid_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  assign push_ok_s = push && (count_r < CNT_W'(DEPTH));
  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/dlbf_data_maxis_rd.sv
// BRAM port-B reader feeding an AXI4-Stream master: issues reads under FIFO
// credit, tags returning data with address/TLAST, and reports progress to the CDC.
module dlbf_data_maxis_rd
  import dlbf_data_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic              m_axis_clk,
  input  logic              m_axis_aresetn,
  input  logic              go,
  input  logic              soft_rst,
  input  logic [11:0]       niter,
  input  logic [11:0]       block_size,
  input  logic [ADDR_W-1:0] rollover_addr,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [ADDR_W-1:0] addrb_status,
  output logic              done
);

  localparam int OCC_W = $clog2(FIFO_D + 1);

  state_t            state_r;
  logic              go_q_r;
  logic [11:0]       niter_r, bsize_r, bcnt_r, pass_r;
  logic [ADDR_W-1:0] roll_r, addr_r, status_r;
  logic              enb_r, done_r;
  logic [OCC_W-1:0]  occ_r, occ_next_s, fifo_count_s;
  logic [RD_LAT-1:0] tag_vld_r, tag_last_r;
  logic [ADDR_W-1:0] tag_addr_r [RD_LAT];
  logic              go_edge_s, pop_s, end_pass_s, tlast_s, last_issue_s, can_issue_s;
  logic              fifo_empty_s;
  fifo_entry_t       push_entry_s, head_s;

  assign go_edge_s    = go & ~go_q_r;
  assign end_pass_s   = (addr_r == roll_r);
  assign tlast_s      = (bcnt_r == bsize_r - 12'd1) || end_pass_s;
  assign last_issue_s = enb_r && end_pass_s && (pass_r == niter_r - 12'd1);
  assign pop_s        = m_axis_tvalid && m_axis_tready;
  // occ counts beats issued but not yet accepted, so the FIFO always has room for them
  assign occ_next_s   = occ_r + OCC_W'(enb_r) - OCC_W'(pop_s);
  assign can_issue_s  = (occ_next_s < OCC_W'(FIFO_D));
  assign push_entry_s = {tag_last_r[RD_LAT-1], tag_addr_r[RD_LAT-1], bram_doutb};

  dlbf_data_skid_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (m_axis_clk),
    .rst_n (m_axis_aresetn),
    .clr   (soft_rst),
    .push  (tag_vld_r[RD_LAT-1]),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (head_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  // Sequencer FSM, address/beat/pass counters and status registers
  always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_r  <= ST_IDLE;
      go_q_r   <= 1'b0;
      niter_r  <= 12'd0;
      bsize_r  <= 12'd1;
      bcnt_r   <= 12'd0;
      pass_r   <= 12'd0;
      roll_r   <= {ADDR_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      status_r <= {ADDR_W{1'b0}};
      enb_r    <= 1'b0;
      done_r   <= 1'b0;
      occ_r    <= {OCC_W{1'b0}};
    end else if (soft_rst) begin
      state_r  <= ST_IDLE;
      go_q_r   <= go;
      niter_r  <= 12'd0;
      bsize_r  <= 12'd1;
      bcnt_r   <= 12'd0;
      pass_r   <= 12'd0;
      roll_r   <= {ADDR_W{1'b0}};
      addr_r   <= {ADDR_W{1'b0}};
      status_r <= {ADDR_W{1'b0}};
      enb_r    <= 1'b0;
      done_r   <= 1'b0;
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      go_q_r <= go;
      occ_r  <= occ_next_s;
      done_r <= (state_r == ST_DONE) && go;
      if (pop_s) status_r <= head_s.addr;
      if (enb_r) begin
        addr_r <= end_pass_s ? {ADDR_W{1'b0}} : addr_r + ADDR_W'(1);
        bcnt_r <= tlast_s ? 12'd0 : bcnt_r + 12'd1;
        if (end_pass_s) pass_r <= pass_r + 12'd1;
      end
      case (state_r)
        ST_IDLE: begin
          enb_r <= 1'b0;
          if (go_edge_s) begin
            niter_r <= niter;
            bsize_r <= (block_size == 12'd0) ? 12'd1 : block_size;
            roll_r  <= rollover_addr;
            addr_r  <= {ADDR_W{1'b0}};
            bcnt_r  <= 12'd0;
            pass_r  <= 12'd0;
            if (niter == 12'd0) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_RUN;
              enb_r   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (last_issue_s) begin
            state_r <= ST_DRAIN;
            enb_r   <= 1'b0;
          end else begin
            enb_r <= can_issue_s;
          end
        end
        ST_DRAIN: begin
          enb_r <= 1'b0;
          if ((fifo_count_s == {OCC_W{1'b0}}) && !(|tag_vld_r)) state_r <= ST_DONE;
        end
        ST_DONE: begin
          enb_r <= 1'b0;
          if (!go) state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          enb_r   <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency tag pipe: stage RD_LAT-1 lines up with bram_doutb
  always_ff @(posedge m_axis_clk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      tag_vld_r  <= {RD_LAT{1'b0}};
      tag_last_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) tag_addr_r[i] <= {ADDR_W{1'b0}};
    end else if (soft_rst) begin
      tag_vld_r  <= {RD_LAT{1'b0}};
      tag_last_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) tag_addr_r[i] <= {ADDR_W{1'b0}};
    end else begin
      tag_vld_r[0]  <= enb_r;
      tag_last_r[0] <= tlast_s;
      tag_addr_r[0] <= addr_r;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_r[i]  <= tag_vld_r[i-1];
        tag_last_r[i] <= tag_last_r[i-1];
        tag_addr_r[i] <= tag_addr_r[i-1];
      end
    end
  end

  assign m_axis_tvalid = ~fifo_empty_s;
  assign m_axis_tdata  = fifo_empty_s ? {DATA_W{1'b0}} : head_s.data;
  assign m_axis_tlast  = ~fifo_empty_s & head_s.tlast;
  assign bram_enb      = enb_r;
  assign bram_addrb    = addr_r;
  assign addrb_status  = status_r;
  assign done          = done_r;

endmodule
